// File: rtl/hyper_burst_splitter.sv
// Splits one hyper transfer descriptor into page/max-burst bounded bursts,
// tagging each with first/last/index, with zero-size and abort handling.
module hyper_burst_splitter #(
   parameter int ADDR_WIDTH = 32,
   parameter int L2_AWIDTH  = 12,
   parameter int TRANS_SIZE = 16,
   parameter int ID_WIDTH   = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_rw_i,
   input  logic                  req_reg_i,
   input  logic [ADDR_WIDTH-1:0] req_hyper_addr_i,
   input  logic [L2_AWIDTH-1:0]  req_l2_addr_i,
   input  logic [TRANS_SIZE-1:0] req_size_i,
   input  logic [2:0]            req_page_bound_i,
   input  logic [TRANS_SIZE-1:0] req_max_burst_i,
   input  logic [ID_WIDTH:0]     req_id_i,
   input  logic                  abort_i,
   output logic                  burst_valid_o,
   input  logic                  burst_ready_i,
   output logic [ADDR_WIDTH-1:0] burst_hyper_addr_o,
   output logic [L2_AWIDTH-1:0]  burst_l2_addr_o,
   output logic [TRANS_SIZE-1:0] burst_size_o,
   output logic                  burst_rw_o,
   output logic                  burst_reg_o,
   output logic [ID_WIDTH:0]     burst_id_o,
   output logic                  burst_first_o,
   output logic                  burst_last_o,
   output logic [TRANS_SIZE-1:0] burst_idx_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int LW = (TRANS_SIZE > 11) ? TRANS_SIZE : 11;
   localparam logic [ID_WIDTH:0] NO_ID = {1'b1, {ID_WIDTH{1'b0}}};

   typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [L2_AWIDTH-1:0]  l2_q, l2_d;
   logic [TRANS_SIZE-1:0] rem_q, rem_d;
   logic [TRANS_SIZE-1:0] idx_q, idx_d;
   logic [TRANS_SIZE-1:0] mb_q, mb_d;
   logic [2:0]            pb_q, pb_d;
   logic                  rw_q, rw_d;
   logic                  reg_q, reg_d;
   logic [ID_WIDTH:0]     id_q, id_d;

   logic [10:0]           page_sz, page_off, room_raw;
   logic [LW-1:0]         rem_x, room_x, mb_x, len_x;
   logic [TRANS_SIZE-1:0] len;
   logic                  accept, hs, is_last;

   // Burst length: bounded by remaining bytes, room to the page end and max burst.
   always_comb begin
      page_sz  = 11'd128 << pb_q[1:0];
      page_off = {1'b0, addr_q[9:0]} & (page_sz - 11'd1);
      room_raw = page_sz - page_off;
      rem_x    = LW'(rem_q);
      room_x   = pb_q[2] ? rem_x : LW'(room_raw);
      mb_x     = (mb_q == '0) ? rem_x : LW'(mb_q);
      len_x    = rem_x;
      if (room_x < len_x) len_x = room_x;
      if (mb_x < len_x)   len_x = mb_x;
      len      = reg_q ? rem_q : TRANS_SIZE'(len_x);
   end

   assign accept  = req_valid_i & req_ready_o;
   assign hs      = burst_valid_o & burst_ready_i;
   assign is_last = (rem_q == len);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         l2_q    <= '0;
         rem_q   <= '0;
         idx_q   <= '0;
         mb_q    <= '0;
         pb_q    <= '0;
         rw_q    <= 1'b0;
         reg_q   <= 1'b0;
         id_q    <= NO_ID;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         l2_q    <= l2_d;
         rem_q   <= rem_d;
         idx_q   <= idx_d;
         mb_q    <= mb_d;
         pb_q    <= pb_d;
         rw_q    <= rw_d;
         reg_q   <= reg_d;
         id_q    <= id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = (req_size_i == '0) ? DONE : BURST;
         BURST:   if (abort_i || (hs && is_last)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_d = addr_q;
      l2_d   = l2_q;
      rem_d  = rem_q;
      idx_d  = idx_q;
      mb_d   = mb_q;
      pb_d   = pb_q;
      rw_d   = rw_q;
      reg_d  = reg_q;
      id_d   = id_q;
      if (accept) begin
         addr_d = req_hyper_addr_i;
         l2_d   = req_l2_addr_i;
         rem_d  = req_size_i;
         idx_d  = '0;
         mb_d   = req_max_burst_i;
         pb_d   = req_page_bound_i;
         rw_d   = req_rw_i;
         reg_d  = req_reg_i;
         id_d   = req_id_i;
      end else if (hs) begin
         // A handshake coinciding with abort still retires its burst.
         addr_d = addr_q + ADDR_WIDTH'(len);
         l2_d   = l2_q + L2_AWIDTH'(len);
         rem_d  = rem_q - len;
         idx_d  = idx_q + 1'b1;
      end else if (state_q == DONE) begin
         id_d   = NO_ID;
      end
   end

   always_comb begin
      req_ready_o   = (state_q == IDLE);
      burst_valid_o = (state_q == BURST);
      busy_o        = (state_q != IDLE);
      done_o        = (state_q == DONE);
   end

   assign burst_hyper_addr_o = addr_q;
   assign burst_l2_addr_o    = l2_q;
   assign burst_size_o       = len;
   assign burst_rw_o         = rw_q;
   assign burst_reg_o        = reg_q;
   assign burst_id_o         = id_q;
   assign burst_first_o      = (idx_q == '0);
   assign burst_last_o       = is_last;
   assign burst_idx_o        = idx_q;

endmodule

// File: tb/tb_hyper_burst_splitter.sv
// Directed bench for hyper_burst_splitter: inputs driven and outputs sampled on the falling edge.
module tb_hyper_burst_splitter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i, req_ready_o, req_rw_i, req_reg_i;
   logic [31:0] req_hyper_addr_i;
   logic [11:0] req_l2_addr_i;
   logic [15:0] req_size_i, req_max_burst_i;
   logic [2:0]  req_page_bound_i;
   logic [1:0]  req_id_i;
   logic        abort_i, burst_valid_o, burst_ready_i;
   logic [31:0] burst_hyper_addr_o;
   logic [11:0] burst_l2_addr_o;
   logic [15:0] burst_size_o, burst_idx_o;
   logic        burst_rw_o, burst_reg_o, burst_first_o, burst_last_o, busy_o, done_o;
   logic [1:0]  burst_id_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   hyper_burst_splitter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_rw_i(req_rw_i), .req_reg_i(req_reg_i),
      .req_hyper_addr_i(req_hyper_addr_i), .req_l2_addr_i(req_l2_addr_i),
      .req_size_i(req_size_i), .req_page_bound_i(req_page_bound_i),
      .req_max_burst_i(req_max_burst_i), .req_id_i(req_id_i),
      .abort_i(abort_i),
      .burst_valid_o(burst_valid_o), .burst_ready_i(burst_ready_i),
      .burst_hyper_addr_o(burst_hyper_addr_o), .burst_l2_addr_o(burst_l2_addr_o),
      .burst_size_o(burst_size_o), .burst_rw_o(burst_rw_o), .burst_reg_o(burst_reg_o),
      .burst_id_o(burst_id_o), .burst_first_o(burst_first_o), .burst_last_o(burst_last_o),
      .burst_idx_o(burst_idx_o), .busy_o(busy_o), .done_o(done_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_i);
   endtask

   task automatic chk_burst(input string tag, input logic [31:0] a, input logic [11:0] l2,
                            input logic [15:0] sz, input logic [15:0] idx,
                            input logic first, input logic last);
      chk({tag, ".valid"}, 32'(burst_valid_o), 32'd1);
      chk({tag, ".addr"},  burst_hyper_addr_o, a);
      chk({tag, ".l2"},    32'(burst_l2_addr_o), 32'(l2));
      chk({tag, ".size"},  32'(burst_size_o), 32'(sz));
      chk({tag, ".idx"},   32'(burst_idx_o), 32'(idx));
      chk({tag, ".first"}, 32'(burst_first_o), 32'(first));
      chk({tag, ".last"},  32'(burst_last_o), 32'(last));
   endtask

   // Presents a descriptor for one cycle; returns on the falling edge after acceptance.
   task automatic send(input logic rw, input logic rg, input logic [31:0] a, input logic [11:0] l2,
                       input logic [15:0] sz, input logic [2:0] pb, input logic [15:0] mb,
                       input logic [1:0] id);
      chk("send.ready", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b1; req_rw_i = rw; req_reg_i = rg; req_hyper_addr_i = a;
      req_l2_addr_i = l2; req_size_i = sz; req_page_bound_i = pb; req_max_burst_i = mb;
      req_id_i = id;
      step();
      req_valid_i = 1'b0;
   endtask

   task automatic chk_done(input string tag);
      chk({tag, ".done_valid"}, 32'(burst_valid_o), 32'd0);
      chk({tag, ".done"},       32'(done_o), 32'd1);
      chk({tag, ".done_busy"},  32'(busy_o), 32'd1);
      step();
      chk({tag, ".idle_done"},  32'(done_o), 32'd0);
      chk({tag, ".idle_ready"}, 32'(req_ready_o), 32'd1);
      chk({tag, ".idle_id"},    32'(burst_id_o), 32'd2);
   endtask

   initial begin
      rst_i = 1'b1; req_valid_i = 1'b0; req_rw_i = 1'b0; req_reg_i = 1'b0;
      req_hyper_addr_i = '0; req_l2_addr_i = '0; req_size_i = '0; req_page_bound_i = '0;
      req_max_burst_i = '0; req_id_i = '0; abort_i = 1'b0; burst_ready_i = 1'b1;
      step(); step();
      chk("rst.ready", 32'(req_ready_o), 32'd1);
      chk("rst.valid", 32'(burst_valid_o), 32'd0);
      chk("rst.done",  32'(done_o), 32'd0);
      chk("rst.busy",  32'(busy_o), 32'd0);
      chk("rst.id",    32'(burst_id_o), 32'd2);
      chk("rst.addr",  burst_hyper_addr_o, 32'd0);
      chk("rst.idx",   32'(burst_idx_o), 32'd0);
      chk("rst.rw",    32'(burst_rw_o), 32'd0);
      rst_i = 1'b0;
      step();

      // 1: page crossing at 0x100 with 128 B pages
      send(1'b1, 1'b0, 32'h0F0, 12'h010, 16'h40, 3'd0, 16'd0, 2'd1);
      chk_burst("t1b0", 32'h0F0, 12'h010, 16'd16, 16'd0, 1'b1, 1'b0);
      chk("t1.rw", 32'(burst_rw_o), 32'd1);
      chk("t1.id", 32'(burst_id_o), 32'd1);
      step();
      chk_burst("t1b1", 32'h100, 12'h020, 16'd48, 16'd1, 1'b0, 1'b1);
      step();
      chk_done("t1");

      // 2: max burst limit, no page limit
      send(1'b0, 1'b0, 32'h0, 12'h0, 16'd100, 3'd4, 16'd32, 2'd0);
      for (int i = 0; i < 4; i++) begin
         chk_burst($sformatf("t2b%0d", i), 32'(32 * i), 12'(32 * i),
                   (i == 3) ? 16'd4 : 16'd32, 16'(i), i == 0, i == 3);
         step();
      end
      chk_done("t2");

      // 3: register access ignores the one-byte page room
      send(1'b0, 1'b1, 32'h7F, 12'h0, 16'd4, 3'd0, 16'd0, 2'd1);
      chk_burst("t3b0", 32'h7F, 12'h0, 16'd4, 16'd0, 1'b1, 1'b1);
      chk("t3.reg", 32'(burst_reg_o), 32'd1);
      step();
      chk_done("t3");

      // 4: zero size goes straight to DONE
      send(1'b1, 1'b0, 32'h40, 12'h0, 16'd0, 3'd0, 16'd0, 2'd1);
      chk("t4.noready", 32'(req_ready_o), 32'd0);
      chk_done("t4");

      // 5: stall freezes outputs, then abort with two bursts left
      send(1'b0, 1'b0, 32'h0, 12'h0, 16'd64, 3'd4, 16'd16, 2'd0);
      chk_burst("t5b0", 32'h0, 12'h0, 16'd16, 16'd0, 1'b1, 1'b0);
      step();
      burst_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk_burst($sformatf("t5stall%0d", i), 32'd16, 12'd16, 16'd16, 16'd1, 1'b0, 1'b0);
         step();
      end
      burst_ready_i = 1'b1;
      chk_burst("t5b1", 32'd16, 12'd16, 16'd16, 16'd1, 1'b0, 1'b0);
      step();
      chk_burst("t5b2", 32'd32, 12'd32, 16'd16, 16'd2, 1'b0, 1'b0);
      burst_ready_i = 1'b0;
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      burst_ready_i = 1'b1;
      chk("t5.abort_idx", 32'(burst_idx_o), 32'd2);
      chk_done("t5");

      // 6: reset in the middle of a transfer
      send(1'b1, 1'b0, 32'h0, 12'h0, 16'd64, 3'd4, 16'd16, 2'd1);
      step();
      chk_burst("t6b1", 32'd16, 12'd16, 16'd16, 16'd1, 1'b0, 1'b0);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("t6.valid", 32'(burst_valid_o), 32'd0);
      chk("t6.id",    32'(burst_id_o), 32'd2);
      chk("t6.done",  32'(done_o), 32'd0);
      chk("t6.ready", 32'(req_ready_o), 32'd1);
      chk("t6.busy",  32'(busy_o), 32'd0);
      step();
      chk("t6.done2", 32'(done_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
